text_writer: RTL and testbench



---
 rtl/text_writer_if.sv | 25 ++
 rtl/text_writer.sv | 163 ++++++++++++++++
 tb/tb_text_writer.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/text_writer_if.sv
// text_writer_if: byte-stream input handshake plus character-RAM write port of text_writer.
`default_nettype none

interface text_writer_if;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [10:0] write_character_pos;
  logic [7:0]  write_character;
  logic        write_strobe;
  logic [10:0] cursor_pos;
  logic        busy;

  modport master (
    output in_data, in_valid,
    input  in_ready, write_character_pos, write_character, write_strobe, cursor_pos, busy
  );

  modport slave (
    input  in_data, in_valid,
    output in_ready, write_character_pos, write_character, write_strobe, cursor_pos, busy
  );
endinterface

`default_nettype wire

// File: rtl/text_writer.sv
// ============================================================================
// text_writer : terminal-style byte interpreter driving the VGA character RAM.
// Option macro: TEXT_WRITER_CLEAR_ON_RESET_EN (blank whole screen after reset).
// Revision: 1.0
// ============================================================================
`default_nettype none

module text_writer #(
  parameter int          COLS       = 80,
  parameter int          ROWS       = 25,
  parameter logic [7:0]  BLANK_CHAR = 8'h20
) (
  input  logic          CLK,
  input  logic          n_reset,
  text_writer_if.slave  bus
);

  localparam logic [10:0] LAST_COL  = 11'(COLS - 1);
  localparam logic [10:0] LAST_ROW  = 11'(ROWS - 1);
  localparam logic [10:0] COLS_W    = 11'(COLS);
  localparam logic [11:0] LINE_CNT  = 12'(COLS);
  localparam logic [11:0] TOTAL_CNT = 12'(COLS * ROWS);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    CLEAR_LINE   = 2'd1,
    CLEAR_SCREEN = 2'd2
  } state_t;

  state_t      state;
  logic [10:0] row;
  logic [10:0] col;
  logic [10:0] row_base;
  logic [10:0] cursor;
  logic [10:0] clr_addr;
  logic [11:0] clr_cnt;
  logic        ready;
  logic        busy_flag;
  logic        strobe;
  logic [10:0] wr_pos;
  logic [7:0]  wr_char;

  logic        accept;
  logic        printable;
  logic        last_row;
  logic [10:0] next_row;
  logic [10:0] next_base;

  assign accept    = ready && bus.in_valid;
  assign printable = (bus.in_data >= 8'h20) && (bus.in_data != 8'h7F);
  assign last_row  = (row == LAST_ROW);
  assign next_row  = last_row ? 11'd0 : row + 11'd1;
  // Row base is tracked incrementally so no row*COLS multiply is needed.
  assign next_base = last_row ? 11'd0 : row_base + COLS_W;

  assign bus.in_ready            = ready;
  assign bus.busy                = busy_flag;
  assign bus.write_strobe        = strobe;
  assign bus.write_character_pos = wr_pos;
  assign bus.write_character     = wr_char;
  assign bus.cursor_pos          = cursor;

  always_ff @(posedge CLK or negedge n_reset) begin
    if (!n_reset) begin
      row      <= '0;
      col      <= '0;
      row_base <= '0;
      cursor   <= '0;
      clr_addr <= '0;
      strobe   <= 1'b0;
      wr_pos   <= '0;
      wr_char  <= '0;
`ifdef TEXT_WRITER_CLEAR_ON_RESET_EN
      state     <= CLEAR_SCREEN;
      ready     <= 1'b0;
      busy_flag <= 1'b1;
      clr_cnt   <= TOTAL_CNT;
`else
      state     <= IDLE;
      ready     <= 1'b1;
      busy_flag <= 1'b0;
      clr_cnt   <= '0;
`endif
    end else begin
      strobe <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (printable) begin
              strobe  <= 1'b1;
              wr_pos  <= cursor;
              wr_char <= bus.in_data;
              if (col == LAST_COL) begin
                col       <= '0;
                row       <= next_row;
                row_base  <= next_base;
                cursor    <= next_base;
                clr_addr  <= next_base;
                clr_cnt   <= LINE_CNT;
                state     <= CLEAR_LINE;
                ready     <= 1'b0;
                busy_flag <= 1'b1;
              end else begin
                col    <= col + 11'd1;
                cursor <= cursor + 11'd1;
              end
            end else if (bus.in_data == 8'h0D) begin
              col    <= '0;
              cursor <= row_base;
            end else if (bus.in_data == 8'h0A) begin
              row       <= next_row;
              row_base  <= next_base;
              cursor    <= next_base + col;
              clr_addr  <= next_base;
              clr_cnt   <= LINE_CNT;
              state     <= CLEAR_LINE;
              ready     <= 1'b0;
              busy_flag <= 1'b1;
            end else if (bus.in_data == 8'h08) begin
              if (col != 11'd0) begin
                col    <= col - 11'd1;
                cursor <= cursor - 11'd1;
              end
            end else if (bus.in_data == 8'h0C) begin
              row       <= '0;
              col       <= '0;
              row_base  <= '0;
              cursor    <= '0;
              clr_addr  <= '0;
              clr_cnt   <= TOTAL_CNT;
              state     <= CLEAR_SCREEN;
              ready     <= 1'b0;
              busy_flag <= 1'b1;
            end
          end
        end

        CLEAR_LINE, CLEAR_SCREEN: begin
          strobe   <= 1'b1;
          wr_pos   <= clr_addr;
          wr_char  <= BLANK_CHAR;
          clr_addr <= clr_addr + 11'd1;
          clr_cnt  <= clr_cnt - 12'd1;
          // Hand back to IDLE on the edge that issues the final blank.
          if (clr_cnt == 12'd1) begin
            state     <= IDLE;
            ready     <= 1'b1;
            busy_flag <= 1'b0;
          end
        end

        default: begin
          state     <= IDLE;
          ready     <= 1'b1;
          busy_flag <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_text_writer.sv
// tb_text_writer: directed + randomized checks of text_writer against a row/col terminal model.
`default_nettype none

module tb_text_writer;
  localparam int COLS = 80;
  localparam int ROWS = 25;

  logic CLK = 1'b0;
  logic n_reset = 1'b1;
  always #5 CLK = ~CLK;

  text_writer_if bus();

  text_writer #(.COLS(COLS), .ROWS(ROWS), .BLANK_CHAR(8'h20)) dut (
    .CLK     (CLK),
    .n_reset (n_reset),
    .bus     (bus)
  );

  int checks = 0;
  int failures = 0;
  int obs_count = 0;
  int mrow = 0;
  int mcol = 0;
  logic [18:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic timeout_fail(input string tag);
    checks++;
    failures++;
    $display("FAIL %s timeout waiting on DUT", tag);
  endtask

  // Scoreboard: each strobe must match the oldest expected write.
  always @(negedge CLK) begin
    if (n_reset && bus.write_strobe === 1'b1) begin
      logic [18:0] e;
      obs_count++;
      checks++;
      assert (exp_q.size() != 0) else begin
        failures++;
        $error("FAIL unexpected_strobe observed=%0h/%0h expected=none",
               bus.write_character_pos, bus.write_character);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        checks++;
        assert ({bus.write_character_pos, bus.write_character} === e) else begin
          failures++;
          $error("FAIL strobe observed=%0h/%0h expected=%0h/%0h",
                 bus.write_character_pos, bus.write_character, e[18:8], e[7:0]);
        end
      end
    end
  end

  function automatic int mcursor();
    return mrow * COLS + mcol;
  endfunction

  function automatic void push_blank(input int first, input int count);
    for (int a = first; a < first + count; a++)
      exp_q.push_back({11'(a), 8'h20});
  endfunction

  function automatic void model_byte(input logic [7:0] b);
    if (b >= 8'h20 && b != 8'h7F) begin
      exp_q.push_back({11'(mcursor()), b});
      if (mcol == COLS - 1) begin
        mcol = 0;
        mrow = (mrow + 1) % ROWS;
        push_blank(mrow * COLS, COLS);
      end else begin
        mcol++;
      end
    end else if (b == 8'h0D) begin
      mcol = 0;
    end else if (b == 8'h0A) begin
      mrow = (mrow + 1) % ROWS;
      push_blank(mrow * COLS, COLS);
    end else if (b == 8'h08) begin
      if (mcol > 0) mcol--;
    end else if (b == 8'h0C) begin
      mrow = 0;
      mcol = 0;
      push_blank(0, COLS * ROWS);
    end
  endfunction

  task automatic do_reset();
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    n_reset = 1'b1;
    #1 n_reset = 1'b0;
    repeat (2) @(negedge CLK);
    exp_q.delete();
    mrow = 0;
    mcol = 0;
    n_reset = 1'b1;
    @(posedge CLK);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    while (bus.in_ready !== 1'b1 && n < 5000) begin
      @(posedge CLK);
      #1;
      n++;
    end
    if (n >= 5000) timeout_fail("send_ready");
    bus.in_data  = b;
    bus.in_valid = 1'b1;
    model_byte(b);
    @(posedge CLK);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic settle();
    int n = 0;
    @(negedge CLK);
    while (bus.in_ready !== 1'b1 && n < 5000) begin
      @(negedge CLK);
      n++;
    end
    if (n >= 5000) timeout_fail("settle");
    #1;
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
  endtask

  // Counts cycles with in_ready low right after a clear-triggering accept.
  task automatic measure_clear(input string tag, input int expected_len);
    int low = 0;
    int busy_hi = 0;
    int n = 0;
    forever begin
      @(negedge CLK);
      if (bus.in_ready === 1'b1 || n >= 5000) break;
      low++;
      if (bus.busy === 1'b1) busy_hi++;
      n++;
    end
    if (n >= 5000) timeout_fail(tag);
    #1;
    chk({tag, "_ready_low"}, 32'(low), 32'(expected_len));
    chk({tag, "_busy_high"}, 32'(busy_hi), 32'(expected_len));
    chk({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;

    // 1: reset values and a single printable byte
    do_reset();
    chk("rst_strobe", 32'(bus.write_strobe), 32'd0);
    chk("rst_pos", 32'(bus.write_character_pos), 32'd0);
    chk("rst_char", 32'(bus.write_character), 32'd0);
    chk("rst_cursor", 32'(bus.cursor_pos), 32'd0);
    chk("rst_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    send_byte(8'h41);
    chk("t1_strobe", 32'(bus.write_strobe), 32'd1);
    chk("t1_ready", 32'(bus.in_ready), 32'd1);
    settle();
    chk("t1_cursor", 32'(bus.cursor_pos), 32'd1);

    // 2: back-to-back with CR in the middle
    do_reset();
    send_byte(8'h48);
    send_byte(8'h49);
    send_byte(8'h0D);
    send_byte(8'h58);
    settle();
    chk("t2_cursor", 32'(bus.cursor_pos), 32'(mcursor()));
    chk("t2_cursor_abs", 32'(bus.cursor_pos), 32'd1);

    // 3: LF from column 5 blanks the next row
    do_reset();
    for (int i = 0; i < 5; i++) send_byte(8'h78);
    settle();
    send_byte(8'h0A);
    measure_clear("t3", COLS);
    chk("t3_cursor", 32'(bus.cursor_pos), 32'd85);

    // 4: auto-wrap after a full line
    do_reset();
    for (int i = 0; i < COLS; i++) send_byte(8'h61);
    settle();
    chk("t4_cursor", 32'(bus.cursor_pos), 32'd80);

    // 5: LF from the bottom row wraps to row 0, then BS past column 0
    do_reset();
    for (int i = 0; i < ROWS - 1; i++) begin
      send_byte(8'h0A);
      settle();
    end
    for (int i = 0; i < 3; i++) send_byte(8'h7A);
    settle();
    chk("t5_cursor_1923", 32'(bus.cursor_pos), 32'd1923);
    send_byte(8'h0A);
    measure_clear("t5", COLS);
    chk("t5_cursor_wrap", 32'(bus.cursor_pos), 32'd3);
    for (int i = 0; i < 4; i++) send_byte(8'h08);
    settle();
    chk("t5_cursor_bs", 32'(bus.cursor_pos), 32'd0);

    // 6: form feed clears the screen
    send_byte(8'h7E);
    send_byte(8'h0C);
    measure_clear("t6", COLS * ROWS);
    chk("t6_cursor", 32'(bus.cursor_pos), 32'd0);

    // 6b: reset mid-clear abandons it
    send_byte(8'h0C);
    begin
      int n = 0;
      obs_count = 0;
      while (obs_count < 500 && n < 5000) begin
        @(negedge CLK);
        #1;
        n++;
      end
      if (n >= 5000) timeout_fail("t6b_wait");
    end
    chk("t6b_mid_busy", 32'(bus.busy), 32'd1);
    n_reset = 1'b0;
    #1;
    chk("t6b_strobe_async", 32'(bus.write_strobe), 32'd0);
    chk("t6b_busy_async", 32'(bus.busy), 32'd0);
    chk("t6b_cursor_async", 32'(bus.cursor_pos), 32'd0);
    exp_q.delete();
    mrow = 0;
    mcol = 0;
    @(negedge CLK);
    n_reset = 1'b1;
    @(posedge CLK);
    #1;
    chk("t6b_ready_after", 32'(bus.in_ready), 32'd1);
    repeat (10) @(negedge CLK);
    #1;
    chk("t6b_no_resume", 32'(exp_q.size()), 32'd0);

    // Randomized bursts against the model
    for (int burst = 0; burst < 60; burst++) begin
      int len = $urandom_range(1, 6);
      for (int k = 0; k < len; k++) begin
        int r = $urandom_range(0, 99);
        logic [7:0] b;
        if (r < 60)      b = 8'($urandom_range(32, 126));
        else if (r < 68) b = 8'($urandom_range(128, 255));
        else if (r < 76) b = 8'h0A;
        else if (r < 83) b = 8'h0D;
        else if (r < 91) b = 8'h08;
        else if (r < 92) b = 8'h0C;
        else begin
          case ($urandom_range(0, 4))
            0: b = 8'h00;
            1: b = 8'h07;
            2: b = 8'h09;
            3: b = 8'h1B;
            default: b = 8'h7F;
          endcase
        end
        send_byte(b);
      end
      settle();
      chk("rand_cursor", 32'(bus.cursor_pos), 32'(mcursor()));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
